// File: rtl/bkram_sd_sequencer_if.sv
// Sector-transfer handshake between the backup-RAM sequencer and the HPS SD block.
interface bkram_sd_sequencer_if;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;

  modport master (input sd_ack, output sd_lba, output sd_rd, output sd_wr);
  modport slave  (output sd_ack, input sd_lba, input sd_rd, input sd_wr);
endinterface

// File: rtl/bkram_sd_sequencer.sv
// Backup-RAM load/save sequencer: steps SECTORS sector reads or writes through the HPS SD handshake.
// Define BKRAM_AUTOLOAD_EN to start a load automatically when a cartridge download ends.
module bkram_sd_sequencer #(
  parameter int unsigned SECTORS = 64
) (
  input  logic                       clk_sys,
  input  logic                       RESET_n,
  input  logic                       bk_load,
  input  logic                       bk_save,
  input  logic                       downloading,
  input  logic                       img_mounted,
  input  logic                       img_readonly,
  input  logic [63:0]                img_size,
  bkram_sd_sequencer_if.master       sd,
  output logic                       bk_ena,
  output logic                       bk_loading,
  output logic                       bk_state
);

  localparam int unsigned     LBA_W    = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam logic [LBA_W-1:0] LBA_LAST = LBA_W'(SECTORS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             loading_q, loading_d;
  logic             busy_q, busy_d;
  logic             ena_q, ena_d;
  logic             dl_q, load_q, save_q, ack_q;

  logic load_req_c, save_req_c;
  logic load_edge_c, save_edge_c, auto_edge_c;
  logic ack_rise_c, ack_fall_c;

  // Requests only count while the backup file is usable.
  assign load_req_c  = bk_load & ena_q;
  assign save_req_c  = bk_save & ena_q;
  assign load_edge_c = load_req_c & ~load_q;
  assign save_edge_c = save_req_c & ~save_q;
  assign ack_rise_c  = sd.sd_ack & ~ack_q;
  assign ack_fall_c  = ~sd.sd_ack & ack_q;

`ifdef BKRAM_AUTOLOAD_EN
  assign auto_edge_c = dl_q & ~downloading & (img_size != 64'd0) & ena_q;
`else
  logic unused_img_size;
  assign unused_img_size = ^img_size;
  assign auto_edge_c     = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    busy_d    = busy_q;
    ena_d     = ena_q;

    if (downloading & ~dl_q)                          ena_d = 1'b0;
    if (downloading & img_mounted & ~img_readonly)    ena_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (load_edge_c | auto_edge_c) begin
          state_d   = S_REQ;
          lba_d     = '0;
          loading_d = 1'b1;
          rd_d      = 1'b1;
          wr_d      = 1'b0;
          busy_d    = 1'b1;
        end else if (save_edge_c) begin
          state_d   = S_REQ;
          lba_d     = '0;
          loading_d = 1'b0;
          rd_d      = 1'b0;
          wr_d      = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_REQ: begin
        if (ack_rise_c) begin
          state_d = S_XFER;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      S_XFER: begin
        if (ack_fall_c) begin
          if (lba_q == LBA_LAST) begin
            state_d   = S_IDLE;
            loading_d = 1'b0;
            busy_d    = 1'b0;
          end else begin
            state_d = S_REQ;
            lba_d   = lba_q + LBA_W'(1);
            rd_d    = loading_q;
            wr_d    = ~loading_q;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        loading_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= S_IDLE;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      loading_q <= 1'b0;
      busy_q    <= 1'b0;
      ena_q     <= 1'b0;
      dl_q      <= 1'b0;
      load_q    <= 1'b0;
      save_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      loading_q <= loading_d;
      busy_q    <= busy_d;
      ena_q     <= ena_d;
      dl_q      <= downloading;
      load_q    <= load_req_c;
      save_q    <= save_req_c;
      ack_q     <= sd.sd_ack;
    end
  end

  assign sd.sd_lba  = 32'(lba_q);
  assign sd.sd_rd   = rd_q;
  assign sd.sd_wr   = wr_q;
  assign bk_ena     = ena_q;
  assign bk_loading = loading_q;
  assign bk_state   = busy_q;

endmodule

// File: tb/tb_bkram_sd_sequencer.sv
// Directed bench for bkram_sd_sequencer: acts as the HPS side of the sector handshake.
module tb_bkram_sd_sequencer;

  logic        clk_sys = 1'b0;
  logic        RESET_n;
  logic        bk_load, bk_save, downloading, img_mounted, img_readonly;
  logic [63:0] img_size;
  logic        bk_ena, bk_loading, bk_state;
  int          total = 0;
  int          bad   = 0;

  bkram_sd_sequencer_if sd_bus ();

  bkram_sd_sequencer #(.SECTORS(64)) dut (
    .clk_sys      (clk_sys),
    .RESET_n      (RESET_n),
    .bk_load      (bk_load),
    .bk_save      (bk_save),
    .downloading  (downloading),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .sd           (sd_bus),
    .bk_ena       (bk_ena),
    .bk_loading   (bk_loading),
    .bk_state     (bk_state)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serve sectors first..first+n-1, holding ack ack_len cycles each.
  task automatic serve(input int first, input int n, input int ack_len, input bit is_rd);
    for (int i = first; i < first + n; i++) begin
      int k = 0;
      while (!(sd_bus.sd_rd | sd_bus.sd_wr) && k < 20) begin
        step(1);
        k++;
      end
      chk("req_seen", 32'(sd_bus.sd_rd | sd_bus.sd_wr), 32'd1);
      chk("req_rd",   32'(sd_bus.sd_rd), 32'(is_rd));
      chk("req_wr",   32'(sd_bus.sd_wr), 32'(!is_rd));
      chk("req_lba",  sd_bus.sd_lba, 32'(i));
      chk("req_load", 32'(bk_loading), 32'(is_rd));
      chk("req_busy", 32'(bk_state), 32'd1);
      sd_bus.sd_ack = 1'b1;
      step(1);
      chk("req_drop", 32'(sd_bus.sd_rd | sd_bus.sd_wr), 32'd0);
      if (ack_len > 1) step(ack_len - 1);
      sd_bus.sd_ack = 1'b0;
      step(1);
    end
  endtask

  initial begin
    RESET_n = 1'b0; bk_load = 1'b0; bk_save = 1'b0; downloading = 1'b0;
    img_mounted = 1'b0; img_readonly = 1'b0; img_size = 64'd0; sd_bus.sd_ack = 1'b0;
    step(2);
    chk("rst_ena",  32'(bk_ena), 32'd0);
    chk("rst_busy", 32'(bk_state), 32'd0);
    chk("rst_rdwr", 32'({sd_bus.sd_rd, sd_bus.sd_wr}), 32'd0);
    chk("rst_lba",  sd_bus.sd_lba, 32'd0);
    RESET_n = 1'b1;
    step(2);

    // Writable mount during a download enables the backup file.
    downloading = 1'b1;
    step(1);
    chk("dl_ena0", 32'(bk_ena), 32'd0);
    img_mounted = 1'b1;
    step(1);
    img_mounted = 1'b0;
    chk("mount_ena", 32'(bk_ena), 32'd1);
    img_size = 64'd32768;
    downloading = 1'b0;
    step(1);
`ifdef BKRAM_AUTOLOAD_EN
    chk("auto_lat", 32'(sd_bus.sd_rd), 32'd1);
    serve(0, 64, 3, 1'b1);
    step(1);
    chk("auto_done_busy", 32'(bk_state), 32'd0);
    chk("auto_done_load", 32'(bk_loading), 32'd0);
    chk("auto_done_lba",  sd_bus.sd_lba, 32'd63);
`else
    step(5);
    chk("noauto_rd",   32'(sd_bus.sd_rd), 32'd0);
    chk("noauto_busy", 32'(bk_state), 32'd0);
`endif

    // Save, 10-cycle acks.
    bk_save = 1'b1;
    step(1);
    bk_save = 1'b0;
    chk("save_lat", 32'(sd_bus.sd_wr), 32'd1);
    serve(0, 64, 10, 1'b0);
    step(1);
    chk("save_busy", 32'(bk_state), 32'd0);
    chk("save_lba",  sd_bus.sd_lba, 32'd63);
    chk("save_wr",   32'(sd_bus.sd_wr), 32'd0);

    // Load and save in the same cycle: load wins.
    bk_load = 1'b1; bk_save = 1'b1;
    step(1);
    bk_load = 1'b0; bk_save = 1'b0;
    chk("both_rd",   32'(sd_bus.sd_rd), 32'd1);
    chk("both_wr",   32'(sd_bus.sd_wr), 32'd0);
    chk("both_load", 32'(bk_loading), 32'd1);
    serve(0, 64, 2, 1'b1);
    step(1);
    chk("both_done", 32'(bk_state), 32'd0);

    // Save re-pulsed during sector 5 is ignored and not queued.
    bk_save = 1'b1;
    step(1);
    bk_save = 1'b0;
    serve(0, 5, 2, 1'b0);
    bk_save = 1'b1;
    step(1);
    bk_save = 1'b0;
    serve(5, 59, 2, 1'b0);
    step(1);
    chk("ign_busy", 32'(bk_state), 32'd0);
    step(3);
    chk("ign_noq_busy", 32'(bk_state), 32'd0);
    chk("ign_noq_rdwr", 32'({sd_bus.sd_rd, sd_bus.sd_wr}), 32'd0);

    // Reset asserted during sector 20 aborts asynchronously.
    bk_load = 1'b1;
    step(1);
    bk_load = 1'b0;
    serve(0, 20, 2, 1'b1);
    sd_bus.sd_ack = 1'b1;
    step(1);
    #2 RESET_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bk_state), 32'd0);
    chk("arst_load", 32'(bk_loading), 32'd0);
    chk("arst_ena",  32'(bk_ena), 32'd0);
    chk("arst_lba",  sd_bus.sd_lba, 32'd0);
    chk("arst_rdwr", 32'({sd_bus.sd_rd, sd_bus.sd_wr}), 32'd0);
    sd_bus.sd_ack = 1'b0;
    step(2);
    RESET_n = 1'b1;
    step(2);
    chk("post_rst_busy", 32'(bk_state), 32'd0);

    // Read-only mount leaves the backup file disabled.
    downloading = 1'b1;
    step(1);
    img_mounted = 1'b1; img_readonly = 1'b1;
    step(1);
    img_mounted = 1'b0;
    downloading = 1'b0;
    step(1);
    bk_load = 1'b1;
    step(1);
    chk("ro_ena",  32'(bk_ena), 32'd0);
    chk("ro_rd",   32'(sd_bus.sd_rd), 32'd0);
    step(3);
    chk("ro_busy", 32'(bk_state), 32'd0);
    chk("ro_rd2",  32'(sd_bus.sd_rd), 32'd0);
    bk_load = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
